floor_tracker: RTL and testbench

//  Consumes the 16-bit cm distance from the HC-SR04 driver (car-to-floor sensor) and turns it

---
 rtl/floor_tracker_pkg.sv | 15 +
 rtl/floor_tracker_divider.sv | 71 +++++++
 rtl/floor_tracker.sv | 133 +++++++++++++
 tb/tb_floor_tracker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/floor_tracker_pkg.sv
// Shared encodings for the floor tracker: FSM states and direction codes.
package floor_tracker_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAP,
        S_DIV,
        S_CLASS
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

// File: rtl/floor_tracker_divider.sv
// Maps a latched distance to a floor band by repeated subtraction of FLOOR_CM.
// Results are held from one done pulse until the next start.
module floor_divider #(
    parameter int BASE_CM    = 5,
    parameter int FLOOR_CM   = 20,
    parameter int TOL_CM     = 3,
    parameter int NUM_FLOORS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] d,
    output logic        done,
    output logic [2:0]  q,
    output logic        in_band,
    output logic        oor
);

    localparam logic [16:0] TOL17   = 17'(TOL_CM);
    localparam logic [16:0] BASE17  = 17'(BASE_CM);
    localparam logic [16:0] FLOOR17 = 17'(FLOOR_CM);
    localparam logic [16:0] BAND17  = 17'(2 * TOL_CM);
    localparam logic [2:0]  QMAX    = 3'(NUM_FLOORS - 1);

    logic [16:0] d_ext;
    logic [16:0] x;
    logic [2:0]  q_work;
    logic        busy;

    // 17 bits so distance=16'hFFFF plus tolerance cannot wrap.
    assign d_ext = {1'b0, d} + TOL17;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            q_work  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= '0;
            in_band <= 1'b0;
            oor     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                if (d == 16'd0 || d_ext < BASE17) begin
                    oor     <= 1'b1;
                    in_band <= 1'b0;
                    q       <= '0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end else begin
                    x      <= d_ext - BASE17;
                    q_work <= '0;
                    busy   <= 1'b1;
                end
            end else if (busy) begin
                if (x >= FLOOR17 && q_work < QMAX) begin
                    x      <= x - FLOOR17;
                    q_work <= q_work + 3'd1;
                end else begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    q       <= q_work;
                    in_band <= (x <= BAND17);
                    oor     <= (x > BAND17) && (q_work == QMAX);
                end
            end
        end
    end

endmodule

// File: rtl/floor_tracker.sv
// Periodically samples the sensor distance, classifies it into a floor band and
// debounces the result into an accepted floor with arrival/direction/motion flags.
module floor_tracker
    import floor_tracker_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 1_200_000,
    parameter int BASE_CM       = 5,
    parameter int FLOOR_CM      = 20,
    parameter int TOL_CM        = 3,
    parameter int NUM_FLOORS    = 4,
    parameter int CONFIRM       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] distance,
    output logic [2:0]  floor,
    output logic        floor_valid,
    output logic        arrive,
    output logic [1:0]  dir,
    output logic        moving,
    output logic        out_of_range
);

    localparam int             TW    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [TW-1:0]  TMAX  = TW'(SAMPLE_CYCLES - 1);
    localparam logic [3:0]     CONF4 = 4'(CONFIRM);

    state_t        state;
    logic [TW-1:0] timer;
    logic          tick;
    logic [15:0]   cap;
    logic          start;
    logic [2:0]    cand;
    logic [3:0]    count;
    logic [3:0]    next_count;
    logic          div_done;
    logic [2:0]    div_q;
    logic          div_in_band;
    logic          div_oor;

    assign tick = (timer == TMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer <= '0;
        else        timer <= tick ? '0 : timer + 1'b1;
    end

    floor_divider #(
        .BASE_CM   (BASE_CM),
        .FLOOR_CM  (FLOOR_CM),
        .TOL_CM    (TOL_CM),
        .NUM_FLOORS(NUM_FLOORS)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .d      (cap),
        .done   (div_done),
        .q      (div_q),
        .in_band(div_in_band),
        .oor    (div_oor)
    );

    always_comb begin
        next_count = 4'd1;
        if (div_q == cand) next_count = (count >= CONF4) ? CONF4 : count + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cap          <= '0;
            start        <= 1'b0;
            cand         <= '0;
            count        <= '0;
            floor        <= '0;
            floor_valid  <= 1'b0;
            arrive       <= 1'b0;
            dir          <= DIR_NONE;
            moving       <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            start  <= 1'b0;
            arrive <= 1'b0;
            case (state)
                S_IDLE: if (tick) begin
                    cap   <= distance;
                    state <= S_CAP;
                end
                // The sensor register lives in a slower domain; accept only a value
                // seen unchanged on two consecutive cycles.
                S_CAP: begin
                    if (distance == cap) begin
                        start <= 1'b1;
                        state <= S_DIV;
                    end else begin
                        cap <= distance;
                    end
                end
                S_DIV: if (div_done) state <= S_CLASS;
                S_CLASS: begin
                    state <= S_IDLE;
                    if (div_oor) begin
                        out_of_range <= 1'b1;
                        moving       <= 1'b0;
                        count        <= '0;
                    end else if (!div_in_band) begin
                        out_of_range <= 1'b0;
                        moving       <= 1'b1;
                        count        <= '0;
                    end else begin
                        out_of_range <= 1'b0;
                        cand         <= div_q;
                        count        <= next_count;
                        if (next_count == CONF4) begin
                            moving <= 1'b0;
                            if (!floor_valid || div_q != floor) begin
                                floor       <= div_q;
                                floor_valid <= 1'b1;
                                arrive      <= 1'b1;
                                if (!floor_valid)       dir <= DIR_NONE;
                                else if (div_q > floor) dir <= DIR_UP;
                                else                    dir <= DIR_DOWN;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floor_tracker.sv
// Bench for floor_tracker: directed vector table, CAP/reset corner sequences and
// randomized distances checked against a band-arithmetic reference model.
module tb_floor_tracker;

    localparam int SC      = 100;
    localparam int BASE    = 5;
    localparam int FLR     = 20;
    localparam int TOL     = 3;
    localparam int NF      = 4;
    localparam int CONF    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] distance = '0;
    logic [2:0]  floor;
    logic        floor_valid, arrive, moving, out_of_range;
    logic [1:0]  dir;

    always #5 clk = ~clk;

    floor_tracker #(.SAMPLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .distance(distance), .floor(floor),
        .floor_valid(floor_valid), .arrive(arrive), .dir(dir),
        .moving(moving), .out_of_range(out_of_range)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int arr_cnt  = 0;

    always @(negedge clk) if (arrive) arr_cnt++;

    // Reference model state, in terms of the behavioural rules only.
    int m_cand, m_count, m_floor, m_valid, m_dir, m_moving, m_oor, m_arr;

    task automatic model_reset();
        m_cand = 0; m_count = 0; m_floor = 0; m_valid = 0;
        m_dir = 0; m_moving = 0; m_oor = 0;
    endtask

    task automatic model_sample(input int d);
        int band = -1;
        for (int k = 0; k < NF; k++)
            if (d >= BASE + FLR * k - TOL && d <= BASE + FLR * k + TOL) band = k;
        if (d == 0 || (band < 0 && (d < BASE - TOL || d > BASE + FLR * (NF - 1) + TOL))) begin
            m_oor = 1; m_moving = 0; m_count = 0;
        end else if (band < 0) begin
            m_oor = 0; m_moving = 1; m_count = 0;
        end else begin
            m_oor = 0;
            if (band == m_cand) m_count = (m_count + 1 > CONF) ? CONF : m_count + 1;
            else begin m_cand = band; m_count = 1; end
            if (m_count == CONF) begin
                m_moving = 0;
                if (!m_valid || band != m_floor) begin
                    m_dir   = !m_valid ? 0 : (band > m_floor ? 1 : 2);
                    m_floor = band;
                    m_valid = 1;
                    m_arr++;
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int fl, input int vl, input int dr,
                              input int mv, input int oo);
        check({tag, " floor"}, int'(floor), fl);
        check({tag, " floor_valid"}, int'(floor_valid), vl);
        check({tag, " dir"}, int'(dir), dr);
        check({tag, " moving"}, int'(moving), mv);
        check({tag, " out_of_range"}, int'(out_of_range), oo);
    endtask

    // Hold d for exactly one sample period; starts and ends mid-period.
    task automatic step(input logic [15:0] d);
        distance = d;
        repeat (SC) @(negedge clk);
    endtask

    typedef struct {
        int d;
        int fl, vl, dr, mv, oo, ar;
    } vec_t;

    vec_t tbl[23];

    initial begin
        int a0, e0;
        logic [15:0] rd;
        logic [15:0] prev;
        tbl[0]  = '{25, 0,0,0,0,0,0};
        tbl[1]  = '{25, 0,0,0,0,0,0};
        tbl[2]  = '{25, 1,1,0,0,0,1};
        tbl[3]  = '{15, 1,1,0,1,0,0};
        tbl[4]  = '{45, 1,1,0,1,0,0};
        tbl[5]  = '{45, 1,1,0,1,0,0};
        tbl[6]  = '{45, 2,1,1,0,0,1};
        tbl[7]  = '{8,  2,1,1,0,0,0};
        tbl[8]  = '{2,  2,1,1,0,0,0};
        tbl[9]  = '{8,  0,1,2,0,0,1};
        tbl[10] = '{9,  0,1,2,1,0,0};
        tbl[11] = '{0,  0,1,2,0,1,0};
        tbl[12] = '{1,  0,1,2,0,1,0};
        tbl[13] = '{72, 0,1,2,0,1,0};
        tbl[14] = '{25, 0,1,2,0,0,0};
        tbl[15] = '{25, 0,1,2,0,0,0};
        tbl[16] = '{45, 0,1,2,0,0,0};
        tbl[17] = '{25, 0,1,2,0,0,0};
        tbl[18] = '{25, 0,1,2,0,0,0};
        tbl[19] = '{25, 1,1,1,0,0,1};
        tbl[20] = '{25, 1,1,1,0,0,0};
        tbl[21] = '{29, 1,1,1,1,0,0};
        tbl[22] = '{22, 1,1,1,1,0,0};

        model_reset();
        m_arr = 0;
        repeat (3) @(negedge clk);
        check_outs("reset", 0, 0, 0, 0, 0);
        check("reset arrive", int'(arrive), 0);
        rst_n = 1'b1;
        repeat (SC / 2) @(negedge clk);

        // Directed vector table
        foreach (tbl[i]) begin
            a0 = arr_cnt;
            step(16'(tbl[i].d));
            model_sample(tbl[i].d);
            check_outs($sformatf("vec%0d", i), tbl[i].fl, tbl[i].vl, tbl[i].dr, tbl[i].mv, tbl[i].oo);
            check($sformatf("vec%0d arrive", i), arr_cnt - a0, tbl[i].ar);
        end

        // Distance toggling every cycle: CAP keeps retrying, no sample may land.
        a0 = arr_cnt;
        for (int i = 0; i < 3 * SC; i++) begin
            distance = (i % 2 != 0) ? 16'd65 : 16'd0;
            @(negedge clk);
        end
        check_outs("toggle", 1, 1, 1, 1, 0);
        check("toggle arrive", arr_cnt - a0, 0);
        // Stable again: the pending capture completes, then the next tick samples.
        step(16'd65);
        model_sample(65);
        model_sample(65);
        check_outs("stable1", 1, 1, 1, 1, 0);
        a0 = arr_cnt;
        step(16'd65);
        model_sample(65);
        check_outs("stable2", 3, 1, 1, 0, 0);
        check("stable2 arrive", arr_cnt - a0, 1);

        // Reset pulsed while the divider is iterating on a top-band distance.
        distance = 16'd68;
        repeat (SC / 2 + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outs("midreset", 0, 0, 0, 0, 0);
        check("midreset arrive", int'(arrive), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        distance = 16'd25;
        a0 = arr_cnt;
        repeat (3 * SC - 10) @(negedge clk);
        check("post-reset early floor_valid", int'(floor_valid), 0);
        repeat (20) @(negedge clk);
        model_sample(25); model_sample(25); model_sample(25);
        check_outs("post-reset", 1, 1, 0, 0, 0);
        check("post-reset arrive", arr_cnt - a0, 1);
        repeat (SC / 2 - 20) @(negedge clk);

        // Randomized distances against the reference model
        prev = 16'd25;
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)       rd = prev;
            else if (r == 4) rd = 16'hFFFF - 16'($urandom_range(0, 3));
            else if (r == 5) rd = 16'($urandom_range(0, 3));
            else             rd = 16'($urandom_range(0, 80));
            prev = rd;
            a0 = arr_cnt;
            e0 = m_arr;
            step(rd);
            model_sample(int'(rd));
            check_outs($sformatf("rnd%0d d=%0d", i, rd), m_floor, m_valid, m_dir, m_moving, m_oor);
            check($sformatf("rnd%0d arrive", i), arr_cnt - a0, m_arr - e0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
